// File: rtl/alu_serial.sv
// Digit-serial ALU: WIDTH-bit ops processed DIGIT bits per cycle.
// Valid/ready on both sides; result and flags held until taken.
module alu_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_TST = 3'b111;

  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;

  int               idx;
  logic [DIGIT-1:0] ad;
  logic [DIGIT-1:0] bl;
  logic [DIGIT-1:0] bx;
  logic [DIGIT-1:0] sum;
  logic [DIGIT-1:0] dig;
  logic             c_nx;
  logic             c_msb;
  logic             is_sub;
  logic             is_arith;
  logic             last;
  logic [WIDTH-1:0] acc_nx;

  // One digit of the selected op from the latched operands and carry reg
  always_comb begin
    idx      = int'(cnt) * DIGIT;
    ad       = DIGIT'(a_q >> idx);
    bl       = DIGIT'(b_q >> idx);
    is_sub   = (op_q == OP_SUB) || (op_q == OP_TST);
    is_arith = (op_q == OP_ADD) || is_sub;
    bx       = is_sub ? ~bl : bl;
    c_nx     = carry;
    c_msb    = 1'b0;
    sum      = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb  = c_nx;
      sum[i] = ad[i] ^ bx[i] ^ c_nx;
      c_nx   = (ad[i] & bx[i]) | (c_nx & (ad[i] ^ bx[i]));
    end
    unique case (op_q)
      OP_AND:  dig = ad & bl;
      OP_NOT:  dig = ~ad;
      OP_OR:   dig = ad | bl;
      OP_XOR:  dig = ad ^ bl;
      OP_MOV:  dig = ad;
      default: dig = sum;
    endcase
    acc_nx = (acc & ~(DMASK << idx)) | (WIDTH'(dig) << idx);
    last   = (cnt == CW'(N - 1));
  end

  // Control FSM, digit datapath and registered result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_AND;
      carry     <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= select;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
            unique case (select)
              OP_ADD:         carry <= carry_in;
              OP_SUB, OP_TST: carry <= 1'b1;
              default:        carry <= 1'b0;
            endcase
          end
        end
        BUSY: begin
          acc   <= acc_nx;
          carry <= c_nx;
          cnt   <= cnt + 1'b1;
          if (last) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= (op_q == OP_TST) ? '0 : acc_nx;
            zero      <= (acc_nx == '0);
            negative  <= acc_nx[WIDTH-1];
            carry_out <= is_arith & c_nx;
            overflow  <= is_arith & (c_msb ^ c_nx);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial at DIGIT = 1, 2, 4, 8 (WIDTH 8).
// Expected results and flags are hand-computed constants.
module tb_alu_serial;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_TST = 3'b111;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic [2:0] select;
  logic       in_valid  [4];
  logic       in_ready  [4];
  logic       out_valid [4];
  logic       out_ready [4];
  logic [7:0] result    [4];
  logic       carry_out [4];
  logic       zero      [4];
  logic       negative  [4];
  logic       overflow  [4];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    alu_serial #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .select    (select),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .result    (result[g]),
      .carry_out (carry_out[g]),
      .zero      (zero[g]),
      .negative  (negative[g]),
      .overflow  (overflow[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags(input int k);
    return {carry_out[k], zero[k], negative[k], overflow[k]};
  endfunction

  // Wait (bounded) for out_valid; n = edges seen
  task automatic wait_ov(input int k, output int n);
    n = 0;
    while (out_valid[k] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // ef = {carry_out, zero, negative, overflow}
  task automatic do_op(input int k, input logic [2:0] s,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input logic [7:0] er,
                       input logic [3:0] ef, input string tag);
    int n;
    @(negedge clk);
    chk({tag, "/rdy"}, 32'(in_ready[k]), 1);
    a = x; b = y; select = s; carry_in = ci;
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid[k] = 1'b0;
    a = ~x; b = ~y; select = ~s; carry_in = ~ci;
    wait_ov(k, n);
    chk({tag, "/lat"}, 32'(n), 32'(8 >> k));
    chk({tag, "/res"}, 32'(result[k]), 32'(er));
    chk({tag, "/flg"}, 32'(flags(k)), 32'(ef));
    @(posedge clk); #1;
    chk({tag, "/ovlo"}, 32'(out_valid[k]), 0);
    chk({tag, "/rdyhi"}, 32'(in_ready[k]), 1);
  endtask

  initial begin
    int n;
    int c0;
    rst = 1'b1;
    a = 8'h11; b = 8'h22; carry_in = 1'b0; select = OP_ADD;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
    end
    in_valid[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rst/rdy", 32'(in_ready[k]), 1);
      chk("rst/ov", 32'(out_valid[k]), 0);
      chk("rst/res", 32'(result[k]), 0);
      chk("rst/flg", 32'(flags(k)), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/noacc", 32'(in_ready[0]), 1);

    do_op(0, OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011, "add7f");
    do_op(0, OP_ADD, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1100, "addcin");
    do_op(2, OP_SUB, 8'h10, 8'h20, 1'b1, 8'hF0, 4'b0010, "sub4");
    do_op(1, OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1001, "subovf");
    do_op(1, OP_TST, 8'h5A, 8'h5A, 1'b0, 8'h00, 4'b1100, "tsteq");
    do_op(1, OP_XOR, 8'hF0, 8'h3C, 1'b1, 8'hCC, 4'b0010, "xor");
    do_op(2, OP_TST, 8'h03, 8'h05, 1'b0, 8'h00, 4'b0010, "tstlt");
    do_op(3, OP_OR,  8'h0F, 8'h50, 1'b0, 8'h5F, 4'b0000, "or8");
    do_op(3, OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h81, 4'b0011, "add8");

    do_op(3, OP_NOT, 8'h00, 8'h12, 1'b0, 8'hFF, 4'b0010, "not8");
    c0 = acc_cyc;
    do_op(3, OP_MOV, 8'hA5, 8'h00, 1'b0, 8'hA5, 4'b0010, "mov8");
    chk("thru", 32'(acc_cyc - c0), 3);

    // Hold in DONE with out_ready low while a new request waits
    @(negedge clk);
    a = 8'h01; b = 8'h02; select = OP_ADD; carry_in = 1'b0;
    in_valid[1] = 1'b1;
    out_ready[1] = 1'b0;
    @(posedge clk); #1;
    select = OP_AND; a = 8'hF0; b = 8'h3C;
    wait_ov(1, n);
    chk("hold/lat", 32'(n), 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold/ov", 32'(out_valid[1]), 1);
      chk("hold/res", 32'(result[1]), 32'h03);
      chk("hold/flg", 32'(flags(1)), 0);
      chk("hold/rdy", 32'(in_ready[1]), 0);
    end
    @(negedge clk);
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("hold/idle", 32'(in_ready[1]), 1);
    chk("hold/ovlo", 32'(out_valid[1]), 0);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    chk("hold/acc", 32'(in_ready[1]), 0);
    wait_ov(1, n);
    chk("hold/lat2", 32'(n), 4);
    chk("hold/res2", 32'(result[1]), 32'h30);
    @(posedge clk); #1;

    // Reset in the middle of an ADD on the DIGIT=1 unit
    @(negedge clk);
    a = 8'h7F; b = 8'h01; select = OP_ADD; carry_in = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst/rdy", 32'(in_ready[0]), 1);
    chk("mrst/ov", 32'(out_valid[0]), 0);
    chk("mrst/res", 32'(result[0]), 0);
    chk("mrst/flg", 32'(flags(0)), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(0, OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000, "and");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
